// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of the ALU op interface in the 19-bit CPU. Accepts one
//   instruction word every four cycles, reads operands from an internal 8x19
//   register file, drives registered operands/op-select to a combinational
//   ALU and writes the result (or an LDI immediate) back to the register file.
//
//   Sequence per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//   Illegal opcodes go through the same four states. They pulse 'illegal'
//   during EXEC, leave the ALU-side registers untouched and perform no write.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   instr_valid/instr instruction handshake input (19-bit word)
//   instr_ready       high only in IDLE
//   alu_a/alu_b       registered operands to the ALU
//   alu_ctrl          registered ALU op select (opcode passed through)
//   alu_result        combinational ALU result
//   alu_negative      combinational ALU result sign
//   wb_valid          high for the cycle whose closing edge writes the regfile
//   wb_rd/wb_data     destination and data of the latest write (held)
//   neg_flag          sign of the last ALU write-back (sticky)
//   div0              write-back of a divide whose divisor was zero
//   illegal           one-cycle pulse for an illegal opcode
//   dbg_addr/dbg_data combinational register file read port
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W = 19,
    parameter int NREG   = 8,
    parameter int OP_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    input  logic [DATA_W-1:0]       instr,
    output logic                    instr_ready,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_ctrl,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_negative,
    output logic                    wb_valid,
    output logic [$clog2(NREG)-1:0] wb_rd,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    neg_flag,
    output logic                    div0,
    output logic                    illegal,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);

    localparam int RW = $clog2(NREG);

    localparam logic [OP_W-1:0] OP_DIV     = 5'd3;
    localparam logic [OP_W-1:0] OP_ALU_MAX = 5'd12;
    localparam logic [OP_W-1:0] OP_LDI     = 5'd13;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] ir;
    logic              nres;
    logic [DATA_W-1:0] regs [NREG];

    // Fields of the latched instruction word.
    logic [OP_W-1:0]   opcode;
    logic [RW-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0] imm;
    logic              is_ldi, is_bad;

    assign opcode = ir[18:14];
    assign rd     = ir[13:11];
    assign rs1    = ir[10:8];
    assign rs2    = ir[7:5];
    assign imm    = {{(DATA_W-11){1'b0}}, ir[10:0]};
    assign is_ldi = (opcode == OP_LDI);
    assign is_bad = (opcode > OP_LDI);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_nxt gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (instr_valid) state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = WB;
            WB:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        instr_ready = (state == IDLE);
        wb_valid    = (state == WB) && !is_bad;
        div0        = (state == WB) && !is_bad && (opcode == OP_DIV) && (alu_b == '0);
        illegal     = (state == EXEC) && is_bad;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            nres     <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            neg_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (instr_valid) ir <= instr;
                DECODE: if (!is_bad) begin
                    alu_a    <= regs[rs1];
                    alu_b    <= regs[rs2];
                    alu_ctrl <= opcode;
                end
                // End of EXEC: the ALU has had a full cycle to settle.
                EXEC: if (!is_bad) begin
                    wb_rd   <= rd;
                    wb_data <= is_ldi ? imm : alu_result;
                    nres    <= alu_negative;
                end
                WB: if (!is_bad && !is_ldi) neg_flag <= nres;
                default: ;
            endcase
        end
    end

    // ---------------- register file ----------------
    // NOTE: the register file is reset explicitly; an abort mid-instruction
    // must leave every entry at zero, so it cannot map to an unreset RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == WB && !is_bad) begin
            regs[rd] <= wb_data;
        end
    end

    assign dbg_data = regs[dbg_addr];

    // OP_ALU_MAX documents the top of the pass-through ALU range; any opcode
    // up to it is forwarded unchanged to alu_ctrl.
    logic unused_ok;
    assign unused_ok = &{1'b0, (opcode <= OP_ALU_MAX), ir[4:0]};

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [18:0] instr = '0;
    logic        instr_ready;
    logic [18:0] alu_a, alu_b;
    logic [4:0]  alu_ctrl;
    logic [18:0] alu_result;
    logic        alu_negative;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [18:0] wb_data;
    logic        neg_flag, div0, illegal;
    logic [2:0]  dbg_addr = '0;
    logic [18:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_negative(alu_negative),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .neg_flag(neg_flag), .div0(div0), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU semantics: add, sub, mul, div, inc, dec, and, or, xor,
    // not; fft/enc/dec and anything else return zero. Divide by zero gives 0.
    function automatic logic [18:0] alu_fn(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a * b;
            5'd3: return (b == 0) ? 19'd0 : a / b;
            5'd4: return a + 19'd1;
            5'd5: return a - 19'd1;
            5'd6: return a & b;
            5'd7: return a | b;
            5'd8: return a ^ b;
            5'd9: return ~a;
            default: return 19'd0;
        endcase
    endfunction

    // ALU environment model.
    always_comb begin
        alu_result   = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_negative = alu_result[18];
    end

    // ---------------- reference state ----------------
    logic [18:0] m_regs [8];
    logic [18:0] m_alu_a, m_alu_b, m_wb_data;
    logic [4:0]  m_alu_ctrl;
    logic [2:0]  m_wb_rd;
    logic        m_neg;
    int          m_wb_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0;
    int wb_count = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wb_valid) wb_count <= wb_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0;
        m_wb_rd = '0; m_wb_data = '0; m_neg = 1'b0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #0.5;
            check($sformatf("%s_R%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    function automatic logic [18:0] enc(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 5'b0};
    endfunction

    function automatic logic [18:0] ldi(input logic [2:0] rd, input logic [10:0] imm);
        return {5'd13, rd, imm};
    endfunction

    // Issues one instruction and checks every phase of its four-cycle life.
    task automatic issue(input logic [18:0] w, input bit hold, input bit chk_gap);
        int waited;
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [18:0] va, vb, res;
        bit          bad, is_ldi;
        op = w[18:14]; rd = w[13:11]; rs1 = w[10:8]; rs2 = w[7:5];
        bad = (op >= 5'd14);
        is_ldi = (op == 5'd13);

        @(negedge clk);
        instr_valid = 1'b1;
        instr = w;
        waited = 0;
        while (!instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", instr_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        if (chk_gap) check("accept_gap", cyc - last_acc, 4);
        last_acc = cyc;

        // Operands are read with all earlier writes complete.
        va = m_regs[rs1];
        vb = m_regs[rs2];
        res = is_ldi ? {8'b0, w[10:0]} : alu_fn(op, va, vb);

        // DECODE
        check("ready_decode", instr_ready, 0);
        @(posedge clk); #1;
        // EXEC
        if (!bad) begin
            m_alu_a = va; m_alu_b = vb; m_alu_ctrl = op;
        end
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_ctrl", alu_ctrl, m_alu_ctrl);
        check("illegal_exec", illegal, bad);
        check("ready_exec", instr_ready, 0);
        check("wb_valid_exec", wb_valid, 0);
        @(posedge clk); #1;
        // WB
        if (!bad) begin
            m_wb_rd = rd; m_wb_data = res;
        end
        check("wb_valid", wb_valid, !bad);
        check("wb_rd", wb_rd, m_wb_rd);
        check("wb_data", wb_data, m_wb_data);
        check("div0", div0, (!bad && op == 5'd3 && vb == 0));
        check("illegal_wb", illegal, 0);
        check("ready_wb", instr_ready, 0);
        @(posedge clk); #1;
        // IDLE
        if (!bad) begin
            m_regs[rd] = res;
            m_wb_count++;
            if (!is_ldi) m_neg = res[18];
        end
        check("ready_idle", instr_ready, 1);
        check("wb_valid_idle", wb_valid, 0);
        check("div0_idle", div0, 0);
        check("neg_flag", neg_flag, m_neg);
        dbg_addr = rd;
        #1;
        check("dbg_rd", dbg_data, m_regs[rd]);
    endtask

    initial begin
        logic [18:0] w;
        int r, wb_before;
        model_reset();
        m_wb_count = 0;

        // Reset state
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", instr_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_neg", neg_flag, 0);
        check("rst_div0", div0, 0);
        check("rst_illegal", illegal, 0);
        check_all_regs("rst");

        // Directed sequence
        issue(ldi(3'd1, 11'd5), 0, 0);
        issue(ldi(3'd2, 11'd3), 0, 0);
        issue(enc(5'd0, 3'd3, 3'd1, 3'd2), 0, 0);   // ADD R3 = 8
        check("add_r3", m_regs[3], 19'd8);
        issue(enc(5'd1, 3'd4, 3'd2, 3'd1), 0, 0);   // SUB R4 = 0x7FFFE
        check("sub_neg", neg_flag, 1);
        issue(enc(5'd3, 3'd5, 3'd1, 3'd0), 0, 0);   // DIV by R0 = 0
        issue(ldi(3'd7, 11'h7FF), 0, 0);            // LDI keeps neg_flag
        issue(enc(5'd31, 3'd1, 3'd2, 3'd3), 0, 0);  // illegal
        check_all_regs("dir");

        // Back-to-back with instr_valid held high
        wb_before = wb_count;
        issue(enc(5'd0, 3'd6, 3'd1, 3'd1), 1, 0);
        issue(enc(5'd0, 3'd6, 3'd6, 3'd2), 1, 1);
        issue(enc(5'd0, 3'd0, 3'd6, 3'd3), 1, 1);
        instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_wb_pulses", wb_count - wb_before, 3);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            w = 19'($urandom);
            if (r < 3)      w[18:14] = 5'd13;
            else if (r < 4) w[18:14] = 5'($urandom_range(14, 31));
            else            w[18:14] = 5'($urandom_range(0, 12));
            issue(w, 0, 0);
        end
        check_all_regs("rand");
        @(negedge clk);
        check("total_wb_pulses", wb_count, m_wb_count);

        // Make state non-trivial, then abort ADD R6 during EXEC
        issue(ldi(3'd1, 11'd9), 0, 0);
        issue(enc(5'd1, 3'd2, 3'd0, 3'd1), 0, 0);   // negative result
        @(negedge clk);
        instr_valid = 1'b1;
        instr = enc(5'd0, 3'd6, 3'd1, 3'd2);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;                          // inside EXEC
        check("abort_in_exec", instr_ready, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_ready", instr_ready, 1);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_alu_ctrl", alu_ctrl, 0);
        check("abort_wb_rd", wb_rd, 0);
        check("abort_wb_data", wb_data, 0);
        check("abort_neg", neg_flag, 0);
        check("abort_wb_valid", wb_valid, 0);
        check_all_regs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        wb_before = wb_count;
        repeat (6) @(negedge clk);
        check("abort_no_wb", wb_count - wb_before, 0);
        check_all_regs("post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
